ml_llr_out: RTL and testbench
=============================

# ml_llr_out

LLR output stage directly downstream of the 4x4 QPSK ML detector. It captures the eight wide signed LLRs the detector emits in one `i_valid` cycle. Each LLR is rounded, shifted and saturated to a narrow symmetric output word, and the quantised vectors are buffered in a small vector FIFO. Vectors are then streamed one LLR per beat over a valid/ready port to the chip output.

## Interface
- `DATA_WIDTH`, 20: detector datapath width; input LLRs are `DATA_WIDTH+2` bits, two's complement.
- `OUT_WIDTH`, 8: output LLR width, two's complement.
- `FRAC_SHIFT`, 8: arithmetic right shift applied before saturation. Must be ≥1.
- `DEPTH`, 2: FIFO depth in 8-LLR vectors. Must be a power of two, ≥2.

Ports:
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_valid` in 1: one-cycle pulse; the eight LLR inputs are valid.
- `i_llr_x11`, `i_llr_x12`, `i_llr_x21`, `i_llr_x22`, `i_llr_x31`, `i_llr_x32`, `i_llr_x41`, `i_llr_x42`, each in `DATA_WIDTH+2`: signed LLRs for stream x1..x4, bit 1/2.
- `o_valid` out 1: `o_llr` holds a valid beat.
- `i_ready` in 1: the consumer accepts the beat.
- `o_llr` out `OUT_WIDTH`: quantised LLR.
- `o_last` out 1: marks the 8th beat (x42) of a vector.
- `o_overflow` out 1: sticky; a vector was dropped because the FIFO was full.
- `o_sat_cnt` out 16: only when `LLR_SAT_CNT_EN` is defined.

## Operation
**Quantisation**, applied per LLR at capture:
- q = (llr + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. The addition is done at `DATA_WIDTH+3` bits, so it never wraps.
- Saturate q to [-(2^(OUT_WIDTH-1)-1), +(2^(OUT_WIDTH-1)-1)]. The most negative code is never produced.

**FIFO**:
- Each entry holds 8×`OUT_WIDTH` bits.
- Write pointer, read pointer and occupancy count are each 1 bit wider than needed; pointers wrap modulo `DEPTH`.
- Push on `i_valid` if not full, or if full while the head's last beat is popped in the same cycle.
- Otherwise the vector is dropped, `o_overflow` is set to 1 and the FIFO is left unchanged.
- Back-to-back `i_valid` pulses are legal.

**Output FSM**, two states:
- IDLE (empty): `o_valid`=0. Go to SEND when count is nonzero.
- SEND: `o_valid`=1 and `o_llr` = head[idx], where the 3-bit idx selects, in order, x11,x12,x21,x22,x31,x32,x41,x42.
  - A beat transfers when `o_valid`&`i_ready`; on transfer, idx increments.
  - `o_last` = (idx==7).
  - Transfer at idx==7: pop the head and set idx to 0. Stay in SEND if another vector remains, else go to IDLE.
- While `i_ready`=0, `o_llr`, `o_last` and idx hold stable.

**Reset** (`i_reset_n`=0 at a clock edge, including mid-vector):
- Pointers, count and idx go to 0; state to IDLE.
- `o_valid`=0, `o_last`=0, `o_llr`=0, `o_overflow`=0, `o_sat_cnt`=0.
- The FIFO storage array itself is not reset.
- An `i_valid` in the reset cycle is ignored.

## Timing
- Latency: `i_valid` sampled at edge T. If the FIFO was empty, `o_valid`=1 with x11 in the cycle after T.
- `o_llr`/`o_last` are a mux of FIFO registers by registered idx; there is no combinational path from the LLR inputs.
- `i_ready`→`o_valid` has no combinational path. `o_valid` depends only on state.
- Throughput: 1 LLR/cycle with `i_ready` held high, i.e. 8 cycles per vector. This exceeds the detector's ≥64-cycle vector rate.
- `o_overflow` is visible the cycle after the dropped `i_valid`.

## Configuration
- `LLR_SAT_CNT_EN` defined:
  - The `o_sat_cnt` port exists: a 16-bit counter adding the number of LLRs clipped in each accepted push (0–8).
  - It saturates at 65535 and clears only on reset. Dropped vectors are not counted.
- Undefined: the port and the counter logic are absent. Quantisation is identical either way.

## Test plan
1. **Rounding.** Reset, then push one vector x11=640, x12=-640, x21=127, x22=128, x31=-129, x32=0, x41=383, x42=384; hold `i_ready`=1.
   - Required beats: 3, -2, 0, 1, -1, 0, 1, 2.
   - `o_last` high only on the 8th beat; `o_valid` drops after it.
2. **Saturation.** Push with all LLRs = 40000, then all = -40000.
   - Required: eight beats of 127, then eight of -127 (never -128).
   - With `LLR_SAT_CNT_EN`, `o_sat_cnt`=16.
3. **Backpressure.** During beat 3 hold `i_ready`=0 for 5 cycles.
   - Required: `o_valid`=1 and `o_llr` unchanged throughout; the stream resumes with beat 3 and no beat is lost or duplicated.
4. **Full and overflow.** With `DEPTH`=2 and `i_ready`=0, push vectors A, B, C.
   - Required: C is dropped and `o_overflow`=1.
   - Release `i_ready`: exactly 16 beats, A then B.
5. **Simultaneous pop/push.** FIFO full, and `i_valid` in the same cycle as A's x42 transfer.
   - Required: the new vector is accepted and `o_overflow` stays 0.
6. **Reset mid-vector.** Assert `i_reset_n`=0 for one cycle at beat 4.
   - Required: next cycle `o_valid`=0 and `o_overflow`=0; a following push streams from x11.

Source files
------------

// File: rtl/ml_llr_out.sv
// LLR output stage: round/shift/saturate eight detector LLRs, buffer vectors, stream one LLR per beat.
// Optional LLR_SAT_CNT_EN adds o_sat_cnt, a saturating count of clipped LLRs in accepted vectors.
module ml_llr_out #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int FRAC_SHIFT = 8,
  parameter int DEPTH      = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_valid,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x11,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x12,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x21,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x22,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x31,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x32,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x41,
  input  logic signed [DATA_WIDTH+1:0]   i_llr_x42,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic signed [OUT_WIDTH-1:0]    o_llr,
  output logic                           o_last,
  output logic                           o_overflow
`ifdef LLR_SAT_CNT_EN
  ,
  output logic [15:0]                    o_sat_cnt
`endif
);

  localparam int IW = DATA_WIDTH + 2;
  localparam int AW = DATA_WIDTH + 3;
  localparam int PW = $clog2(DEPTH);
  localparam int VW = 8 * OUT_WIDTH;
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [AW-1:0] MAXQ = AW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [AW-1:0] MINQ = -MAXQ;

  function automatic logic signed [AW-1:0] round_shift(input logic signed [IW-1:0] x);
    logic signed [AW-1:0] ext;
    ext = {x[IW-1], x};
    return (ext + HALF) >>> FRAC_SHIFT;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [AW-1:0] q);
    logic signed [AW-1:0] r;
    if (q > MAXQ)      r = MAXQ;
    else if (q < MINQ) r = MINQ;
    else               r = q;
    return r[OUT_WIDTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [AW-1:0] q);
    return (q > MAXQ) || (q < MINQ);
  endfunction

  typedef enum logic {IDLE, SEND} state_t;

  logic signed [IW-1:0] llr_in [8];
  logic signed [AW-1:0] q_p0   [8];
  logic [VW-1:0]        qvec_p0;
  logic                 push_p0;
  logic [VW-1:0]        mem [DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic [PW+1:0]        count;
  logic [2:0]           idx;
  logic                 full, pop, drop;
  logic [VW-1:0]        head;
  state_t               state_q, state_d;

  assign llr_in[0] = i_llr_x11;
  assign llr_in[1] = i_llr_x12;
  assign llr_in[2] = i_llr_x21;
  assign llr_in[3] = i_llr_x22;
  assign llr_in[4] = i_llr_x31;
  assign llr_in[5] = i_llr_x32;
  assign llr_in[6] = i_llr_x41;
  assign llr_in[7] = i_llr_x42;

  // p0: quantise at capture
  always_comb begin
    qvec_p0 = '0;
    for (int i = 0; i < 8; i++) begin
      q_p0[i] = round_shift(llr_in[i]);
      qvec_p0[i*OUT_WIDTH +: OUT_WIDTH] = saturate(q_p0[i]);
    end
  end

  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
  assign pop     = (state_q == SEND) && i_ready && (idx == 3'd7);
  assign push_p0 = i_valid && (!full || pop);
  assign drop    = i_valid && full && !pop;
  assign head    = mem[rd_ptr[PW-1:0]];

  // FIFO storage: data only, never reset
  always_ff @(posedge i_clk) begin
    if (push_p0 && i_reset_n) mem[wr_ptr[PW-1:0]] <= qvec_p0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (o_valid && i_ready) idx <= idx + 3'd1;
      if (drop) o_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    o_valid = 1'b0;
    o_llr   = '0;
    o_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (push_p0 || count != '0) state_d = SEND;
      end
      SEND: begin
        o_valid = 1'b1;
        o_llr   = head[idx*OUT_WIDTH +: OUT_WIDTH];
        o_last  = (idx == 3'd7);
        if (pop && !push_p0 && count == (PW+2)'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LLR_SAT_CNT_EN
  logic [7:0]  sat_flags_p0;
  logic [3:0]  sat_num_p0;
  logic [16:0] sat_sum;

  always_comb begin
    for (int i = 0; i < 8; i++) sat_flags_p0[i] = clipped(q_p0[i]);
    sat_num_p0 = 4'($countones(sat_flags_p0));
    sat_sum    = {1'b0, o_sat_cnt} + 17'(sat_num_p0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   o_sat_cnt <= '0;
    else if (push_p0) o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_ml_llr_out.sv
// Scoreboard bench for ml_llr_out: directed vectors queue expected beats, a monitor checks each transfer.
module tb_ml_llr_out;
  localparam int IW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_reset_n, i_valid, i_ready;
  logic signed [IW-1:0] llr [8];
  logic                 o_valid, o_last, o_overflow;
  logic signed [7:0]    o_llr;
`ifdef LLR_SAT_CNT_EN
  logic [15:0]          o_sat_cnt;
`endif

  ml_llr_out #(.DATA_WIDTH(20), .OUT_WIDTH(8), .FRAC_SHIFT(8), .DEPTH(2)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
    .i_llr_x11(llr[0]), .i_llr_x12(llr[1]), .i_llr_x21(llr[2]), .i_llr_x22(llr[3]),
    .i_llr_x31(llr[4]), .i_llr_x32(llr[5]), .i_llr_x41(llr[6]), .i_llr_x42(llr[7]),
    .o_valid(o_valid), .i_ready(i_ready), .o_llr(o_llr), .o_last(o_last),
    .o_overflow(o_overflow)
`ifdef LLR_SAT_CNT_EN
    , .o_sat_cnt(o_sat_cnt)
`endif
  );

  typedef struct packed {
    logic signed [7:0] v;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    vin [8];
  int    qv  [8];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: a beat transfers on the next rising edge when valid & ready
  always @(negedge clk) begin
    if (i_reset_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0d, required none", o_llr);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_llr", int'(o_llr), int'(mon_e.v));
        check("beat_last", int'(o_last), int'(mon_e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit accept);
    beat_t b;
    for (int i = 0; i < 8; i++) llr[i] = IW'(vin[i]);
    i_valid = 1'b1;
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        b.v    = 8'(qv[i]);
        b.last = (i == 7);
        exp_q.push_back(b);
      end
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid_low"}, int'(o_valid), 0);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    tick();
    exp_q.delete();
    check("rst_valid", int'(o_valid), 0);
    check("rst_last", int'(o_last), 0);
    check("rst_llr", int'(o_llr), 0);
    check("rst_overflow", int'(o_overflow), 0);
    i_reset_n = 1'b1;
  endtask

  task automatic set_ramp(input int base, input int sgn);
    for (int i = 0; i < 8; i++) begin
      vin[i] = sgn * (base + i) * 256;
      qv[i]  = sgn * (base + i);
    end
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    for (int i = 0; i < 8; i++) llr[i] = '0;
    tick();
    do_reset();
`ifdef LLR_SAT_CNT_EN
    check("rst_sat_cnt", int'(o_sat_cnt), 0);
`endif

    // Rounding and first-beat latency
    vin = '{640, -640, 127, 128, -129, 0, 383, 384};
    qv  = '{3, -2, 0, 1, -1, 0, 1, 2};
    push(1'b1);
    check("latency_valid", int'(o_valid), 1);
    check("latency_x11", int'(o_llr), 3);
    drain("round");

    // Saturation, back-to-back pushes
    vin = '{40000, 40000, 40000, 40000, 40000, 40000, 40000, 40000};
    qv  = '{127, 127, 127, 127, 127, 127, 127, 127};
    push(1'b1);
    vin = '{-40000, -40000, -40000, -40000, -40000, -40000, -40000, -40000};
    qv  = '{-127, -127, -127, -127, -127, -127, -127, -127};
    push(1'b1);
    drain("sat");
`ifdef LLR_SAT_CNT_EN
    check("sat_cnt", int'(o_sat_cnt), 16);
`endif
    check("sat_no_overflow", int'(o_overflow), 0);

    // Backpressure on beat 3
    set_ramp(1, 1);
    push(1'b1);
    tick();
    tick();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", int'(o_valid), 1);
      check("bp_llr", int'(o_llr), 3);
      check("bp_last", int'(o_last), 0);
    end
    i_ready = 1'b1;
    drain("bp");

    // Full FIFO drops the third vector
    i_ready = 1'b0;
    set_ramp(1, 1);
    push(1'b1);
    set_ramp(1, -1);
    push(1'b1);
    set_ramp(10, 1);
    push(1'b0);
    check("ovf_set", int'(o_overflow), 1);
    check("ovf_holding_valid", int'(o_valid), 1);
    i_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", int'(o_overflow), 1);

    // Push accepted while full in the same cycle the head's last beat pops
    do_reset();
    i_ready = 1'b0;
    set_ramp(1, 1);
    push(1'b1);
    set_ramp(1, -1);
    push(1'b1);
    i_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check("simul_last_shown", int'(o_last), 1);
    set_ramp(20, 1);
    push(1'b1);
    check("simul_no_overflow", int'(o_overflow), 0);
    drain("simul");
    check("simul_no_overflow_end", int'(o_overflow), 0);

    // Reset in the middle of a vector
    set_ramp(1, 1);
    push(1'b1);
    tick();
    tick();
    tick();
    check("mid_beat4", int'(o_llr), 4);
    do_reset();
    vin = '{640, -640, 127, 128, -129, 0, 383, 384};
    qv  = '{3, -2, 0, 1, -1, 0, 1, 2};
    push(1'b1);
    check("after_rst_x11", int'(o_llr), 3);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
